// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM encodings, plus the
// opcode classifier that decides single-cycle vs iterative execution.
package mc_alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_DIV = 4'b0001,
      OP_ADD = 4'b0010,
      OP_MUL = 4'b0011,
      OP_REM = 4'b0100,
      OP_SUB = 4'b0110,
      OP_SLT = 4'b0111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      CLS_SINGLE = 1'b0,
      CLS_ITER   = 1'b1
   } op_class_e;

   // MUL/DIV/REM run on the shared iterative core; everything else,
   // including undefined encodings, completes in one cycle.
   function automatic op_class_e op_class(input logic [3:0] op);
      case (op)
         OP_MUL, OP_DIV, OP_REM: op_class = CLS_ITER;
         default:                op_class = CLS_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_iter_core.sv
// Iterative signed multiply / restoring divide on operand magnitudes.
// One shift register and one counter are shared by both algorithms. The
// first iteration is folded into the start edge, so the last of the WIDTH
// iterations lands WIDTH-1 edges after start and done pulses for one cycle.
module mc_alu_iter_core
   import mc_alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               overflow,
   output logic               div_by_zero
);
   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [RW-1:0]    sr, sr_cur, sr_nxt, shl;
   logic [WIDTH-1:0] opnd, opnd_cur;
   logic             is_mul, is_rem, mul_cur;
   logic             res_neg, a_neg, dbz_q, ovf_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   add_sum, sub_diff;
   logic [WIDTH-1:0] quo, rem, quo_s, rem_s;

   // Magnitudes; the most-negative value maps to 2^(WIDTH-1), still fits unsigned.
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;

   // One iteration step; on the start edge it operates on the freshly loaded operands.
   always_comb begin
      sr_cur   = sr;
      opnd_cur = opnd;
      mul_cur  = is_mul;
      if (start) begin
         mul_cur  = (op == OP_MUL);
         sr_cur   = (op == OP_MUL) ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
         opnd_cur = (op == OP_MUL) ? mag_a : mag_b;
      end
      // shift-add: conditionally add multiplicand to high half, then shift right
      add_sum  = {1'b0, sr_cur[RW-1:WIDTH]} +
                 (sr_cur[0] ? {1'b0, opnd_cur} : {(WIDTH+1){1'b0}});
      // restoring divide: shift left, trial-subtract divisor from partial remainder
      shl      = {sr_cur[RW-2:0], 1'b0};
      sub_diff = {1'b0, shl[RW-1:WIDTH]} - {1'b0, opnd_cur};
      if (mul_cur)
         sr_nxt = {add_sum, sr_cur[WIDTH-1:1]};
      else if (sub_diff[WIDTH])
         sr_nxt = shl;
      else
         sr_nxt = {sub_diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
   end

   // Operand capture, iteration counter and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         sr      <= '0;
         opnd    <= '0;
         is_mul  <= 1'b0;
         is_rem  <= 1'b0;
         res_neg <= 1'b0;
         a_neg   <= 1'b0;
         a_q     <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy    <= 1'b1;
            cnt     <= CW'(1);
            sr      <= sr_nxt;
            opnd    <= opnd_cur;
            is_mul  <= mul_cur;
            is_rem  <= (op == OP_REM);
            res_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg   <= a[WIDTH-1];
            a_q     <= a;
            dbz_q   <= (op != OP_MUL) && (b == '0);
            ovf_q   <= (op == OP_DIV) && (a == MOST_NEG) && (b == '1);
         end else if (busy) begin
            sr <= sr_nxt;
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign quo   = sr[WIDTH-1:0];
   assign rem   = sr[RW-1:WIDTH];
   assign quo_s = res_neg ? -quo : quo;
   assign rem_s = a_neg ? -rem : rem;

   // Sign fix-up and divide-by-zero substitution on the final register contents.
   // MOST_NEG / -1 needs no special case: the negated quotient wraps back to a.
   always_comb begin
      result = '0;
      if (is_mul)
         result = res_neg ? -sr : sr;
      else if (dbz_q)
         result = is_rem ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {RW{1'b1}};
      else if (is_rem)
         result = {{WIDTH{rem_s[WIDTH-1]}}, rem_s};
      else
         result = {{WIDTH{quo_s[WIDTH-1]}}, quo_s};
   end

   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops are computed combinationally from the
// request and captured on acceptance; MUL/DIV/REM go through the iterative
// core. Results and flags are held until the consumer takes them.
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter bit ZERO_ON_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [3:0]         alu_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               zero,
   output logic               overflow,
   output logic               div_by_zero
);
   localparam int RW = 2 * WIDTH;

   state_e           state, state_nxt;
   logic             accept, iter_op, iter_start;
   logic             iter_done, iter_ovf, iter_dbz;
   logic [RW-1:0]    iter_res;
   logic [RW-1:0]    single_res;
   logic             single_ovf;
   logic [WIDTH-1:0] and_w, add_w, sub_w;

   assign accept     = in_valid && in_ready;
   assign iter_op    = (op_class(alu_ctrl) == CLS_ITER);
   assign iter_start = accept && iter_op;

   mc_alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk         (clk),
      .rst         (reset),
      .start       (iter_start),
      .op          (alu_ctrl),
      .a           (a),
      .b           (b),
      .done        (iter_done),
      .result      (iter_res),
      .overflow    (iter_ovf),
      .div_by_zero (iter_dbz)
   );

   assign and_w = a & b;
   assign add_w = a + b + {{(WIDTH-1){1'b0}}, cin};
   assign sub_w = a - b;

   // Single-cycle datapath; results are the WIDTH-bit value sign-extended.
   always_comb begin
      single_res = '0;
      single_ovf = 1'b0;
      case (alu_ctrl)
         OP_AND: single_res = {{WIDTH{and_w[WIDTH-1]}}, and_w};
         OP_ADD: begin
            single_res = {{WIDTH{add_w[WIDTH-1]}}, add_w};
            single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            single_res = {{WIDTH{sub_w[WIDTH-1]}}, sub_w};
            single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: single_res = {{(RW-1){1'b0}}, ($signed(a) < $signed(b))};
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nxt = iter_op ? ST_BUSY : ST_DONE;
         ST_BUSY: if (iter_done) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   // Output registers: load on single-op acceptance or core completion, hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result      <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (accept && !iter_op) begin
         result      <= single_res;
         overflow    <= single_ovf;
         div_by_zero <= 1'b0;
      end else if (state == ST_BUSY && iter_done) begin
         result      <= iter_res;
         overflow    <= iter_ovf;
         div_by_zero <= iter_dbz;
      end
   end

   // Zero flag derived from the held result.
   assign zero = ZERO_ON_LOW ? (result[WIDTH-1:0] == '0) : (result == '0);

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu: a 64-bit instance (full-width zero flag) and an
// 8-bit instance (zero flag on the low half). Expected results are queued
// when a request is driven and checked when out_valid appears.
module tb_mc_alu;

   localparam logic [3:0] C_AND = 4'b0000, C_DIV = 4'b0001, C_ADD = 4'b0010,
                          C_MUL = 4'b0011, C_REM = 4'b0100, C_SUB = 4'b0110,
                          C_SLT = 4'b0111, C_BAD = 4'b1010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst64, iv64, ir64, cin64, ov64, ordy64, z64, ovf64, dbz64;
   logic [63:0]   a64, b64;
   logic [3:0]    op64;
   logic [127:0]  res64;

   logic          rst8, iv8, ir8, cin8, ov8, ordy8, z8, ovf8, dbz8;
   logic [7:0]    a8, b8;
   logic [3:0]    op8;
   logic [15:0]   res8;

   mc_alu #(.WIDTH(64), .ZERO_ON_LOW(1'b0)) u64 (
      .clk(clk), .reset(rst64), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
      .cin(cin64), .alu_ctrl(op64), .out_valid(ov64), .out_ready(ordy64),
      .result(res64), .zero(z64), .overflow(ovf64), .div_by_zero(dbz64));

   mc_alu #(.WIDTH(8), .ZERO_ON_LOW(1'b1)) u8 (
      .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .alu_ctrl(op8), .out_valid(ov8), .out_ready(ordy8),
      .result(res8), .zero(z8), .overflow(ovf8), .div_by_zero(dbz8));

   typedef struct {
      string        tag;
      logic [127:0] res;
      logic         zero, ovf, dbz;
      int           lat;
   } exp_t;

   exp_t sb64[$];
   exp_t sb8[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] op, input int w);
      return (op == C_MUL || op == C_DIV || op == C_REM) ? w + 1 : 1;
   endfunction

   task automatic score(input exp_t e, input int n, input logic v, input logic [127:0] r,
                        input logic z, input logic o, input logic d);
      chk({e.tag, ".valid"}, v, 1'b1);
      chk({e.tag, ".res"}, r, e.res);
      chk({e.tag, ".zero"}, z, e.zero);
      chk({e.tag, ".ovf"}, o, e.ovf);
      chk({e.tag, ".dbz"}, d, e.dbz);
      chk({e.tag, ".lat"}, n, e.lat);
   endtask

   // ---- 64-bit instance ----
   task automatic drive64(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic [127:0] r,
                          input logic o, input logic d);
      exp_t e;
      a64 = a; b64 = b; cin64 = cin; op64 = op; iv64 = 1'b1;
      e.tag = tag; e.res = r; e.zero = (r == '0); e.ovf = o; e.dbz = d;
      e.lat = exp_lat(op, 64);
      sb64.push_back(e);
   endtask

   task automatic wait64();
      exp_t e;
      int   n = 0;
      do begin
         @(posedge clk); n++; #1;
         if (n == 1) begin
            iv64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin64 = 1'($urandom); op64 = 4'($urandom);
         end
      end while (!ov64 && n < 200);
      e = sb64.pop_front();
      score(e, n, ov64, res64, z64, ovf64, dbz64);
      @(posedge clk); #1;
   endtask

   task automatic issue64(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic [127:0] r,
                          input logic o, input logic d);
      @(negedge clk);
      drive64(tag, op, a, b, cin, r, o, d);
      wait64();
   endtask

   task automatic reset_chk64(input string tag);
      chk({tag, ".in_ready"}, ir64, 1'b1);
      chk({tag, ".out_valid"}, ov64, 1'b0);
      chk({tag, ".res"}, res64, '0);
      chk({tag, ".zero"}, z64, 1'b1);
      chk({tag, ".ovf"}, ovf64, 1'b0);
      chk({tag, ".dbz"}, dbz64, 1'b0);
   endtask

   // ---- 8-bit instance; hold>0 keeps out_ready low that many cycles in DONE ----
   task automatic issue8(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [15:0] r,
                         input logic o, input logic d, input int hold);
      exp_t        e;
      int          n = 0;
      logic        stable;
      logic [15:0] snap;
      @(negedge clk);
      ordy8 = (hold == 0);
      a8 = a; b8 = b; cin8 = cin; op8 = op; iv8 = 1'b1;
      e.tag = tag; e.res = {112'b0, r}; e.zero = (r[7:0] == 8'h00); e.ovf = o; e.dbz = d;
      e.lat = exp_lat(op, 8);
      sb8.push_back(e);
      do begin
         @(posedge clk); n++; #1;
         if (n == 1) begin
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
         end
      end while (!ov8 && n < 200);
      e = sb8.pop_front();
      score(e, n, ov8, {112'b0, res8}, z8, ovf8, dbz8);
      if (hold > 0) begin
         stable = 1'b1;
         snap   = res8;
         @(negedge clk);
         op8 = C_SUB; a8 = 8'd9; b8 = 8'd1; iv8 = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (res8 !== snap || ir8 !== 1'b0 || ov8 !== 1'b1) stable = 1'b0;
         end
         chk({tag, ".hold_stable"}, stable, 1'b1);
         @(negedge clk);
         iv8 = 1'b0; ordy8 = 1'b1;
         @(posedge clk); #1;
         chk({tag, ".consumed_ov"}, ov8, 1'b0);
         chk({tag, ".consumed_ir"}, ir8, 1'b1);
         chk({tag, ".not_accepted"}, {112'b0, res8}, {112'b0, r});
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic seen;
      rst64 = 1'b1; iv64 = 1'b0; ordy64 = 1'b1; a64 = '0; b64 = '0; cin64 = 1'b0; op64 = '0;
      rst8  = 1'b1; iv8  = 1'b0; ordy8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; op8  = '0;
      repeat (3) @(negedge clk);
      reset_chk64("rst64");
      chk("rst8.in_ready", ir8, 1'b1);
      chk("rst8.res", {112'b0, res8}, '0);
      chk("rst8.zero", z8, 1'b1);

      // first request on the edge right after reset release
      @(negedge clk);
      rst64 = 1'b0; rst8 = 1'b0;
      drive64("add_ovf", C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b1, 1'b0);
      wait64();

      issue64("mul_neg", C_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
      issue64("add_cin", C_ADD, 64'd2, 64'd3, 1'b1, 128'd6, 1'b0, 1'b0);
      issue64("add_zero", C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 128'd0, 1'b0, 1'b0);
      issue64("sub_neg", C_SUB, 64'd5, 64'd7, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      issue64("sub_ovf", C_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
              128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      issue64("and", C_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0,
              128'h0000_0000_0000_0000_00F0_00F0_00F0_00F0, 1'b0, 1'b0);
      issue64("slt_t", C_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 128'd1, 1'b0, 1'b0);
      issue64("slt_f", C_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'd0, 1'b0, 1'b0);
      issue64("illegal", C_BAD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
              128'd0, 1'b0, 1'b0);
      issue64("mul_minmin", C_MUL, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);

      issue8("div_m7_2", C_DIV, 8'hF9, 8'h02, 1'b0, 16'hFFFD, 1'b0, 1'b0, 0);
      issue8("rem_m7_2", C_REM, 8'hF9, 8'h02, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
      issue8("div_7_m2", C_DIV, 8'h07, 8'hFE, 1'b0, 16'hFFFD, 1'b0, 1'b0, 0);
      issue8("rem_7_m2", C_REM, 8'h07, 8'hFE, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
      issue8("div_min_m1", C_DIV, 8'h80, 8'hFF, 1'b0, 16'hFF80, 1'b1, 1'b0, 0);
      issue8("div_min_min", C_DIV, 8'h80, 8'h80, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
      issue8("div_by0", C_DIV, 8'h05, 8'h00, 1'b0, 16'hFFFF, 1'b0, 1'b1, 0);
      issue8("rem_by0", C_REM, 8'hFA, 8'h00, 1'b0, 16'hFFFA, 1'b0, 1'b1, 0);
      issue8("mul_lowzero", C_MUL, 8'h80, 8'h02, 1'b0, 16'hFF00, 1'b0, 1'b0, 0);
      issue8("mul_max", C_MUL, 8'h7F, 8'h7F, 1'b0, 16'h3F01, 1'b0, 1'b0, 0);
      issue8("add8_ovf", C_ADD, 8'h7F, 8'h01, 1'b0, 16'hFF80, 1'b1, 1'b0, 0);
      issue8("add_hold", C_ADD, 8'h03, 8'h04, 1'b0, 16'h0007, 1'b0, 1'b0, 10);

      // reset in the middle of a MUL aborts it; the next request goes straight in
      @(negedge clk);
      op64 = C_MUL; a64 = 64'hFFFF_FFFF_FFFF_FFFD; b64 = 64'd5; cin64 = 1'b0; iv64 = 1'b1;
      @(posedge clk); #1;
      iv64 = 1'b0;
      chk("mul_abort.busy_ir", ir64, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst64 = 1'b1;
      #1;
      reset_chk64("mul_abort.rst");
      @(negedge clk);
      rst64 = 1'b0;
      drive64("slt_after_rst", C_SLT, 64'd1, 64'd2, 1'b0, 128'd1, 1'b0, 1'b0);
      wait64();
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (ov64) seen = 1'b1;
      end
      chk("mul_abort.no_ghost_valid", seen, 1'b0);
      chk("mul_abort.idle", ir64, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL support any even value 8..64.
REQ-002 Parameter ZERO_ON_LOW, default 0; 1 means the zero flag tests only result[WIDTH-1:0].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  first operand, signed two's complement.
REQ-008 b  input  WIDTH  second operand, signed two's complement.
REQ-009 cin  input  1  carry-in, used by ADD only.
REQ-010 alu_ctrl  input  4  operation select.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  2*WIDTH  signed result.
REQ-014 zero  output  1  result equals zero.
REQ-015 overflow  output  1  signed overflow of ADD/SUB, or DIV of most-negative by -1.
REQ-016 div_by_zero  output  1  DIV/REM issued with b == 0.

Function
REQ-017 Opcodes SHALL be: 0000 AND, 0001 DIV, 0010 ADD, 0011 MUL, 0100 REM, 0110 SUB, 0111 SLT; all others are ILLEGAL.
REQ-018 States SHALL be IDLE, BUSY, DONE; in_ready SHALL equal (state == IDLE).
REQ-019 Acceptance SHALL occur on an edge with in_valid && in_ready; operands and opcode are registered at that edge and later input changes are ignored.
REQ-020 AND, ADD, SUB, SLT, ILLEGAL SHALL go IDLE->DONE; out_valid rises 1 edge after acceptance.
REQ-021 MUL, DIV, REM SHALL go IDLE->BUSY, iterating exactly WIDTH cycles, then BUSY->DONE; out_valid rises WIDTH+1 edges after acceptance.
REQ-022 DONE->IDLE SHALL occur on the edge with out_ready high; result and flags SHALL hold stable while out_valid && !out_ready.
REQ-023 out_ready SHALL be ignored outside DONE; a new request can be accepted no earlier than the edge after the result is consumed.
REQ-024 ADD = a+b+cin; SUB = a-b; both sign-extended to 2*WIDTH; overflow from operand and result sign bits.
REQ-025 MUL SHALL give the full signed 2*WIDTH product via iterative shift-add on magnitudes with final sign fix-up.
REQ-026 DIV/REM SHALL be signed restoring division, quotient truncated toward zero, remainder sign = dividend sign, sign-extended to 2*WIDTH.
REQ-027 b == 0: DIV result SHALL be all ones, REM result SHALL be a; div_by_zero = 1; latency unchanged.
REQ-028 a == most-negative and b == -1: DIV result SHALL be a, REM result 0, overflow = 1.
REQ-029 SLT result SHALL be 1 if a < b (signed), else 0.
REQ-030 ILLEGAL result SHALL be 0 with all flags 0.
REQ-031 overflow and div_by_zero SHALL be 0 for every case not named in REQ-024/027/028.
REQ-032 zero SHALL be computed from the final registered result per ZERO_ON_LOW.

Reset
REQ-033 Reset SHALL force state IDLE, in_ready 1, out_valid 0, result 0, zero 1, overflow 0, div_by_zero 0, iteration counter 0.
REQ-034 Reset asserted in BUSY or DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-035 First acceptance SHALL be possible on the first edge after reset deasserts.

Structure
REQ-036 Package mc_alu_pkg SHALL hold the opcode enum, the state enum and the opcode-to-class (single/iterative) function.
REQ-037 The iterative MUL/DIV datapath SHALL be one sub-module, mc_alu_iter_core, with start/done handshake, shared shift register and counter.
REQ-038 Single-cycle ops SHALL be combinational in mc_alu, captured into the output registers.

Verification
REQ-039 WIDTH=64, ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> 1 edge later out_valid, result sign-extended 0x8000_0000_0000_0000, overflow=1.
REQ-040 WIDTH=64, MUL a=-3, b=5 -> out_valid after 65 edges, result=-15 (128-bit), zero=0.
REQ-041 WIDTH=8, DIV a=-7, b=2 -> quotient -3; REM same operands -> remainder -1; both at 9 edges.
REQ-042 WIDTH=8, DIV a=0x80, b=0xFF -> result 0xFF80, overflow=1; DIV a=5, b=0 -> result 0xFFFF, div_by_zero=1.
REQ-043 out_ready held low 10 cycles in DONE -> result stable, in_ready=0; assert in_valid meanwhile -> not accepted.
REQ-044 Reset pulsed at BUSY cycle 20 of a MUL -> outputs at reset values, no out_valid, new SLT a=1,b=2 accepted next edge -> result 1.
